// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable up/down counter: step classification and boundary mode.
package prog_counter_pkg;

    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_INC,
        STEP_DEC,
        STEP_WRAP,
        STEP_SAT,
        STEP_CLAMP
    } step_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count logic for one enabled step; boundaries are tested before
// any +1/-1 so the arithmetic never wraps on its own.
module prog_counter_next
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] nxt,
    output step_e            step,
    output logic             tc_set,
    output logic             ovf_set
);

    mode_e mode;
    assign mode = mode_e'(sat_mode);

    always_comb begin
        nxt     = cnt;
        step    = STEP_HOLD;
        tc_set  = 1'b0;
        ovf_set = 1'b0;
        if (dir) begin
            if (cnt < limit) begin
                nxt  = cnt + WIDTH'(1);
                step = STEP_INC;
            end else if (mode == MODE_SAT) begin
                nxt    = limit;
                step   = STEP_SAT;
                tc_set = 1'b1;
            end else begin
                nxt     = '0;
                step    = STEP_WRAP;
                tc_set  = 1'b1;
                ovf_set = 1'b1;
            end
        end else begin
            // Count above a freshly lowered limit is pulled back, not a boundary hit.
            if (cnt > limit) begin
                nxt  = limit;
                step = STEP_CLAMP;
            end else if (cnt != '0) begin
                nxt  = cnt - WIDTH'(1);
                step = STEP_DEC;
            end else if (mode == MODE_SAT) begin
                nxt    = '0;
                step   = STEP_SAT;
                tc_set = 1'b1;
            end else begin
                nxt     = limit;
                step    = STEP_WRAP;
                tc_set  = 1'b1;
                ovf_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter: clear > load > step > hold priority mux around the
// count, terminal-count pulse and sticky overflow flops.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] dat_out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_clamped;
    step_e            step;
    logic             tc_set;
    logic             ovf_set;

    prog_counter_next #(.WIDTH(WIDTH)) u_next (
        .cnt      (dat_out),
        .limit    (limit),
        .dir      (dir),
        .sat_mode (sat_mode),
        .nxt      (nxt),
        .step     (step),
        .tc_set   (tc_set),
        .ovf_set  (ovf_set)
    );

    assign load_clamped = (load_val > limit) ? limit : load_val;

    always_comb begin
        assert (tc_set == (step == STEP_WRAP || step == STEP_SAT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_out <= RESET_VAL;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (clear) begin
            dat_out <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            dat_out <= load_clamped;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (enable) begin
            dat_out <= nxt;
            tc      <= tc_set;
            ovf     <= ovf | ovf_set;
        end else begin
            tc      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Directed and randomised checks of prog_counter at WIDTH=4, RESET_VAL=0.
module tb_prog_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable, clear, load, dir, sat_mode;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] dat_out;
    logic         tc, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    prog_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .sat_mode (sat_mode),
        .limit    (limit),
        .dat_out  (dat_out),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the current inputs; leaves time just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int d, input int t, input int o);
        chk({tag, ".dat"}, int'(dat_out), d);
        chk({tag, ".tc"},  int'(tc), t);
        chk({tag, ".ovf"}, int'(ovf), o);
    endtask

    task automatic idle();
        enable = 0; clear = 0; load = 0;
    endtask

    // Reference state for the randomised phase
    int m_cnt, m_tc, m_ovf;

    task automatic model_step(input int en, input int clr, input int ld, input int lv,
                              input int up, input int sat, input int lim);
        m_tc = 0;
        if (clr) begin
            m_cnt = 0; m_ovf = 0;
        end else if (ld) begin
            m_cnt = (lv < lim) ? lv : lim; m_ovf = 0;
        end else if (en) begin
            if (up) begin
                if (m_cnt < lim) m_cnt++;
                else begin
                    m_tc = 1;
                    if (sat) m_cnt = lim;
                    else begin m_cnt = 0; m_ovf = 1; end
                end
            end else begin
                if (m_cnt > lim) m_cnt = lim;
                else if (m_cnt > 0) m_cnt--;
                else begin
                    m_tc = 1;
                    if (!sat) begin m_cnt = lim; m_ovf = 1; end
                end
            end
        end
    endtask

    initial begin
        int exp_d, exp_t, exp_o;
        reset = 1; idle(); dir = 1; sat_mode = 0; load_val = 0; limit = 15;
        #12;
        chk3("rst_init", 0, 0, 0);
        reset = 0;

        // 1. async reset mid-count at 7
        @(negedge clk);
        enable = 1;
        repeat (7) tick();
        chk("pre_rst.dat", int'(dat_out), 7);
        #2;
        reset = 1;
        #1;
        chk3("async_rst", 0, 0, 0);
        @(negedge clk);
        chk3("rst_held", 0, 0, 0);
        reset = 0; idle();

        // 2. up, limit 9, wrap, 11 clocks
        limit = 9; sat_mode = 0; dir = 1; enable = 1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_d = k % 10;
            exp_t = (k == 10) ? 1 : 0;
            exp_o = (k >= 10) ? 1 : 0;
            chk3($sformatf("up_wrap%0d", k), exp_d, exp_t, exp_o);
        end

        // 3. down, limit 5, saturate, from 2
        idle(); load = 1; load_val = 2; limit = 5; sat_mode = 1; dir = 0;
        tick();
        chk3("ld2", 2, 0, 0);
        idle(); enable = 1;
        tick(); chk3("dn_sat1", 1, 0, 0);
        tick(); chk3("dn_sat2", 0, 0, 0);
        tick(); chk3("dn_sat3", 0, 1, 0);
        tick(); chk3("dn_sat4", 0, 1, 0);

        // 4. limit=0 wrap sets ovf, then clear+load+enable, then clamped load
        limit = 0; sat_mode = 0; dir = 1;
        tick(); chk3("lim0_wrap", 0, 1, 1);
        tick(); chk3("lim0_wrap2", 0, 1, 1);
        clear = 1; load = 1; load_val = 3; limit = 10;
        tick(); chk3("clr_pri", 0, 0, 0);
        clear = 0; load_val = 12;
        tick(); chk3("ld_clamp", 10, 0, 0);
        idle();
        tick(); chk3("hold", 10, 0, 0);

        // 5. limit dropped below count while counting up, then down from 0
        load = 1; load_val = 8; limit = 15;
        tick(); chk3("ld8", 8, 0, 0);
        idle(); enable = 1; dir = 1; sat_mode = 0; limit = 4;
        tick(); chk3("lim_drop", 0, 1, 1);
        dir = 0;
        tick(); chk3("dn_wrap0", 4, 1, 1);
        limit = 2;
        tick(); chk3("dn_clamp", 2, 0, 1);

        // 6. full-range wrap then random vs reference model
        idle(); load = 1; load_val = 15; limit = 15;
        tick(); chk3("ld15", 15, 0, 0);
        idle(); enable = 1; dir = 1; sat_mode = 0;
        tick(); chk3("full_wrap", 0, 1, 1);
        m_cnt = 0; m_tc = 1; m_ovf = 1;
        for (int i = 0; i < 10000; i++) begin
            enable   = ($urandom_range(3) != 0);
            dir      = 1'($urandom_range(1));
            sat_mode = 1'($urandom_range(1));
            limit    = 4'($urandom_range(15));
            clear    = ($urandom_range(63) == 0);
            load     = ($urandom_range(31) == 0);
            load_val = 4'($urandom_range(15));
            model_step(int'(enable), int'(clear), int'(load), int'(load_val),
                       int'(dir), int'(sat_mode), int'(limit));
            tick();
            chk3($sformatf("rnd%0d", i), m_cnt, m_tc, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
